bmem_burst_responder: RTL

Synthesizable responder for the cacheline adapter's burst-memory port. It accepts line reads and writes, stores lines in an internal array, and returns read data as four 64-bit beats, low beat first. It sits where the off-chip burst memory sits, for FPGA bring-up and for closed-loop memory-subsystem benches.

---
 rtl/bmem_burst_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bmem_burst_responder.sv
// Burst-memory responder: stores 32-byte lines, accepts 4-beat write bursts and
// returns read lines as four 64-bit beats after a fixed latency, low beat first.
module bmem_burst_responder #(
    parameter int LINES        = 256,
    parameter int READ_LATENCY = 4,
    parameter int Q_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    output logic        proto_err
);

    localparam int IW = $clog2(LINES);
    localparam int CW = $clog2(READ_LATENCY + 1);
    localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int NW = $clog2(Q_DEPTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [NW-1:0] Q_FULL   = NW'(Q_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(Q_DEPTH - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PTR_LAST) ? {PW{1'b0}} : (p + PW'(1));
    endfunction

    logic [255:0]  mem_r [LINES];
    logic [26:0]   q_line_r [Q_DEPTH];
    logic [255:0]  q_data_r [Q_DEPTH];
    logic [CW-1:0] q_cnt_r  [Q_DEPTH];
    logic [PW-1:0] q_head_r, q_tail_r;
    logic [NW-1:0] q_count_r;

    logic          ready_en_r;
    logic          rvalid_r;
    logic [1:0]    beat_r;
    logic [31:0]   raddr_r;
    logic [63:0]   rdata_r;
    logic [255:0]  stream_data_r;
    logic          proto_err_r;
    logic [1:0]    wr_cnt_r;
    logic [IW-1:0] wr_idx_r;

    logic          ready_s, wr_busy_s, rd_accept_s, err_s, wr_take_s;
    logic          stream_free_s, head_go_s, bypass_s, push_s, load_s;
    logic [IW-1:0] rd_idx_s, wr_idx_s;
    logic [255:0]  snap_s, load_data_s;
    logic [26:0]   load_line_s;
    logic [1:0]    next_beat_s;
    logic          unused_addr_s;

    // Handshake, queue and write-steering decisions from registered state and inputs
    always_comb begin
        ready_s       = ready_en_r && (rvalid_r || (q_count_r < Q_FULL));
        wr_busy_s     = (wr_cnt_r != 2'd0);
        rd_idx_s      = bmem_addr[5 +: IW];
        snap_s        = mem_r[rd_idx_s];
        rd_accept_s   = bmem_read && ready_s && !wr_busy_s && (q_count_r < Q_FULL);
        err_s         = (bmem_read && bmem_write) || (bmem_read && wr_busy_s) ||
                        (bmem_read && rvalid_r && (q_count_r == Q_FULL));
        // A read arriving while the write side is idle wins over a same-cycle write beat
        wr_take_s     = bmem_write && ready_s && !(bmem_read && !wr_busy_s);
        wr_idx_s      = wr_busy_s ? wr_idx_r : rd_idx_s;
        stream_free_s = !rvalid_r || (beat_r == 2'd3);
        head_go_s     = (q_count_r != {NW{1'b0}}) && (q_cnt_r[q_head_r] <= CNT_ONE) &&
                        stream_free_s;
        bypass_s      = (READ_LATENCY == 1) && rd_accept_s &&
                        (q_count_r == {NW{1'b0}}) && stream_free_s;
        push_s        = rd_accept_s && !bypass_s;
        load_s        = head_go_s || bypass_s;
        load_data_s   = bypass_s ? snap_s : q_data_r[q_head_r];
        load_line_s   = bypass_s ? bmem_addr[31:5] : q_line_r[q_head_r];
        next_beat_s   = beat_r + 2'd1;
        unused_addr_s = ^bmem_addr[4:0];
    end

    assign bmem_ready  = ready_s;
    assign bmem_raddr  = raddr_r;
    assign bmem_rdata  = rdata_r;
    assign bmem_rvalid = rvalid_r;
    assign proto_err   = proto_err_r;

    // Line storage; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_take_s) begin
            mem_r[wr_idx_s][{wr_cnt_r, 6'd0} +: 64] <= bmem_wdata;
        end
    end

    // Queue payload and per-entry latency countdowns
    always_ff @(posedge clk) begin
        for (int i = 0; i < Q_DEPTH; i++) begin
            if (q_cnt_r[i] != {CW{1'b0}}) begin
                q_cnt_r[i] <= q_cnt_r[i] - CNT_ONE;
            end
        end
        if (push_s) begin
            q_line_r[q_tail_r] <= bmem_addr[31:5];
            q_data_r[q_tail_r] <= snap_s;
            q_cnt_r[q_tail_r]  <= CNT_INIT;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_head_r  <= {PW{1'b0}};
            q_tail_r  <= {PW{1'b0}};
            q_count_r <= {NW{1'b0}};
        end else begin
            if (push_s) begin
                q_tail_r <= ptr_inc(q_tail_r);
            end
            if (head_go_s) begin
                q_head_r <= ptr_inc(q_head_r);
            end
            if (push_s && !head_go_s) begin
                q_count_r <= q_count_r + NW'(1);
            end else if (!push_s && head_go_s) begin
                q_count_r <= q_count_r - NW'(1);
            end
        end
    end

    // Beat streaming, write burst tracking and the sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_r    <= 1'b0;
            rvalid_r      <= 1'b0;
            beat_r        <= 2'd0;
            raddr_r       <= 32'd0;
            rdata_r       <= 64'd0;
            stream_data_r <= 256'd0;
            proto_err_r   <= 1'b0;
            wr_cnt_r      <= 2'd0;
            wr_idx_r      <= {IW{1'b0}};
        end else begin
            ready_en_r <= 1'b1;
            if (err_s) begin
                proto_err_r <= 1'b1;
            end
            if (load_s) begin
                rvalid_r      <= 1'b1;
                beat_r        <= 2'd0;
                raddr_r       <= {load_line_s, 5'd0};
                rdata_r       <= load_data_s[63:0];
                stream_data_r <= load_data_s;
            end else if (rvalid_r && (beat_r != 2'd3)) begin
                beat_r  <= next_beat_s;
                rdata_r <= stream_data_r[{next_beat_s, 6'd0} +: 64];
            end else begin
                rvalid_r <= 1'b0;
                beat_r   <= 2'd0;
                raddr_r  <= 32'd0;
                rdata_r  <= 64'd0;
            end
            if (wr_take_s) begin
                wr_cnt_r <= wr_cnt_r + 2'd1;
                if (!wr_busy_s) begin
                    wr_idx_r <= rd_idx_s;
                end
            end
        end
    end

endmodule
